// File: rtl/ob_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ob_pkg
// Purpose  : Shared types and constants for the order-book command path.
//            Holds the command layout and the deserializer state encoding.
// Revision : 1.0  initial release
// ============================================================================
package ob_pkg;

  // Host link beat width and number of beats that make up one command.
  localparam int CMD_BEAT_W = 32;
  localparam int CMD_BEATS  = 3;
  localparam int CMD_W      = CMD_BEAT_W * CMD_BEATS;

  // Command layout, MSB first: beat0 = {opcode, quantity}, beat1 = uid,
  // beat2 = price.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] quantity;
    logic [31:0] uid;
    logic [31:0] price;
  } cmd_t;

  // Deserializer framing state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ASM  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } deser_state_t;

endpackage
`default_nettype wire

// File: rtl/ob_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ob_sat_cnt
// Purpose  : Event counter that either saturates at all-ones (SAT=1) or
//            wraps modulo 2^WIDTH (SAT=0). At most one increment per cycle.
// Revision : 1.0  initial release
// ============================================================================
module ob_sat_cnt #(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic at_max;

  assign at_max = &cnt;

  // Count one event per cycle; a saturating counter stops at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && !(SAT && at_max)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ob_cmd_deser.sv
`default_nettype none
// ============================================================================
// Module   : ob_cmd_deser
// Purpose  : Assembles sop/eop framed 32-bit beats from the host link into
//            order-book commands, emits each as a one-cycle registered
//            strobe throttled by cmd_full_r, and drops/counts bad frames.
// Revision : 1.0  initial release
// ============================================================================
module ob_cmd_deser
  import ob_pkg::*;
#(
  parameter int W     = 32,  // must match CMD_BEAT_W
  parameter int BEATS = 3,   // must match CMD_BEATS
  parameter int ERR_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [W-1:0]     in_data,
  output logic             in_rdy,
  output logic             cmd_vld_r,
  output cmd_t             cmd_r,
  input  logic             cmd_full_r,
  output logic [ERR_W-1:0] err_cnt_r,
  output logic [CNT_W-1:0] cmd_cnt_r
);

  localparam int             IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int             LAST     = BEATS - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);
  localparam int             TOP_LSB  = LAST * W;

  deser_state_t     state;
  logic [IDX_W-1:0] beat_idx;
  logic             beat_acc;
  logic             err_inc;
  logic             cmd_inc;

  // Beats are refused only while a finished command waits for the order book.
  assign in_rdy   = (state != HOLD);
  assign beat_acc = in_vld && in_rdy;
  assign cmd_inc  = (state == HOLD) && !cmd_full_r;

  // Decode which accepted beats break framing; one increment per cycle max.
  always_comb begin
    err_inc = 1'b0;
    if (beat_acc) begin
      case (state)
        IDLE: err_inc = !(in_sop && !in_eop);
        ASM: begin
          if (in_sop)                    err_inc = 1'b1;
          else if (beat_idx == LAST_IDX) err_inc = !in_eop;
          else                           err_inc = in_eop;
        end
        // A sop restarts assembly silently, but a one-beat frame is still bad.
        DROP:    err_inc = in_sop && in_eop;
        default: err_inc = 1'b0;
      endcase
    end
  end

  // Framing FSM, beat packing and registered command strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat_idx  <= '0;
      cmd_r     <= '0;
      cmd_vld_r <= 1'b0;
    end else begin
      cmd_vld_r <= 1'b0;
      case (state)
        IDLE: begin
          if (beat_acc) begin
            if (in_sop && !in_eop) begin
              cmd_r[TOP_LSB +: W] <= in_data;
              beat_idx            <= IDX_W'(1);
              state               <= ASM;
            end else if (!in_sop && !in_eop) begin
              state <= DROP;
            end
          end
        end
        ASM: begin
          if (beat_acc) begin
            if (in_sop) begin
              // Restart on the new frame; a one-beat restart is abandoned.
              if (in_eop) begin
                state <= IDLE;
              end else begin
                cmd_r[TOP_LSB +: W] <= in_data;
                beat_idx            <= IDX_W'(1);
              end
            end else if (beat_idx == LAST_IDX) begin
              if (in_eop) begin
                cmd_r[W-1:0] <= in_data;
                state        <= HOLD;
              end else begin
                state <= DROP;
              end
            end else if (in_eop) begin
              state <= IDLE;
            end else begin
              cmd_r[(LAST - int'(beat_idx)) * W +: W] <= in_data;
              beat_idx <= beat_idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (!cmd_full_r) begin
            cmd_vld_r <= 1'b1;
            state     <= IDLE;
          end
        end
        DROP: begin
          if (beat_acc) begin
            if (in_sop && !in_eop) begin
              cmd_r[TOP_LSB +: W] <= in_data;
              beat_idx            <= IDX_W'(1);
              state               <= ASM;
            end else if (in_eop) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Framing errors saturate so a flood of junk cannot wrap back to zero.
  ob_sat_cnt #(.WIDTH(ERR_W), .SAT(1'b1)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .cnt (err_cnt_r)
  );

  // Emitted-command counter wraps freely.
  ob_sat_cnt #(.WIDTH(CNT_W), .SAT(1'b0)) u_cmd_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cmd_inc),
    .cnt (cmd_cnt_r)
  );

endmodule
`default_nettype wire

// File: tb/tb_ob_cmd_deser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ob_cmd_deser
// Purpose  : Self-checking bench for ob_cmd_deser with a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ob_cmd_deser;

  localparam int BEATS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [31:0] in_data = '0;
  logic        cmd_full_r = 1'b0;
  logic        in_rdy;
  logic        cmd_vld_r;
  logic [95:0] cmd_r;
  logic [7:0]  err_cnt_r;
  logic [15:0] cmd_cnt_r;

  int passed = 0;
  int total  = 0;
  bit rand_full = 1'b0;

  // Reference model: beats of the frame being collected, a discard flag,
  // expected commands in order, and event totals.
  logic [31:0] frame_q[$];
  bit          discarding;
  logic [95:0] exp_q[$];
  int          model_err;
  int          model_cmd;

  always #5 clk = ~clk;

  ob_cmd_deser #(.W(32), .BEATS(3), .ERR_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_data    (in_data),
    .in_rdy     (in_rdy),
    .cmd_vld_r  (cmd_vld_r),
    .cmd_r      (cmd_r),
    .cmd_full_r (cmd_full_r),
    .err_cnt_r  (err_cnt_r),
    .cmd_cnt_r  (cmd_cnt_r)
  );

  function automatic void model_reset();
    frame_q.delete();
    exp_q.delete();
    discarding = 1'b0;
    model_err  = 0;
    model_cmd  = 0;
  endfunction

  // A good frame is exactly BEATS beats, sop first, eop last, no inner sop.
  function automatic void model_beat(bit s, bit e, logic [31:0] d);
    bit bad = 1'b0;
    if (s) begin
      bad = (frame_q.size() > 0) || e;
      frame_q.delete();
      discarding = 1'b0;
      if (!e) frame_q.push_back(d);
    end else if (discarding) begin
      if (e) discarding = 1'b0;
    end else if (frame_q.size() == 0) begin
      bad = 1'b1;
      discarding = !e;
    end else begin
      frame_q.push_back(d);
      if (frame_q.size() == BEATS) begin
        if (e) begin
          exp_q.push_back({frame_q[0], frame_q[1], frame_q[2]});
          model_cmd++;
        end else begin
          bad = 1'b1;
          discarding = 1'b1;
        end
        frame_q.delete();
      end else if (e) begin
        bad = 1'b1;
        frame_q.delete();
      end
    end
    if (bad) model_err++;
  endfunction

  function automatic int sat_err(int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Strobe monitor: every strobe matches the next expected command, is one
  // cycle wide, and cmd_r holds still while beats are refused.
  logic        prev_vld = 1'b0;
  logic        prev_rdy = 1'b1;
  logic [95:0] prev_cmd = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (cmd_vld_r) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL strobe_unexpected got cmd %h want no strobe", cmd_r);
        end else begin
          logic [95:0] exp_cmd;
          exp_cmd = exp_q.pop_front();
          if (cmd_r !== exp_cmd) $display("FAIL strobe_cmd got %h want %h", cmd_r, exp_cmd);
          else passed++;
        end
        total++;
        if (prev_vld) $display("FAIL strobe_width got 2+ cycles want 1");
        else passed++;
      end
      if (!in_rdy && !prev_rdy) begin
        total++;
        if (cmd_r !== prev_cmd) $display("FAIL hold_stable got %h want %h", cmd_r, prev_cmd);
        else passed++;
      end
    end
    prev_vld = cmd_vld_r;
    prev_rdy = in_rdy;
    prev_cmd = cmd_r;
  end

  task automatic tick();
    @(negedge clk);
    if (rand_full) cmd_full_r = ($urandom_range(0, 99) < 40);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      tick();
      in_vld = 1'b0;
      in_sop = 1'b0;
      in_eop = 1'b0;
    end
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(bit s, bit e, logic [31:0] d);
    int n = 0;
    tick();
    in_vld = 1'b1; in_sop = s; in_eop = e; in_data = d;
    while (!in_rdy) begin
      if (n == 200) begin
        total++;
        $display("FAIL ready_timeout got in_rdy 0 for 200 cycles want 1");
        in_vld = 1'b0;
        return;
      end
      tick();
      n++;
    end
    @(posedge clk);
    #1;
    model_beat(s, e, d);
  endtask

  task automatic send_frame(logic [31:0] d0, logic [31:0] d1, logic [31:0] d2);
    send_beat(1'b1, 1'b0, d0);
    send_beat(1'b0, 1'b0, d1);
    send_beat(1'b0, 1'b1, d2);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    cmd_full_r = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    tick();
    total++; if (in_rdy !== 1'b1)    $display("FAIL rst_in_rdy got %b want 1", in_rdy);     else passed++;
    total++; if (cmd_vld_r !== 1'b0) $display("FAIL rst_cmd_vld got %b want 0", cmd_vld_r); else passed++;
    total++; if (cmd_r !== 96'h0)    $display("FAIL rst_cmd got %h want 0", cmd_r);         else passed++;
    total++; if (err_cnt_r !== 8'h0) $display("FAIL rst_err_cnt got %0d want 0", err_cnt_r); else passed++;
    total++; if (cmd_cnt_r !== 16'h0) $display("FAIL rst_cmd_cnt got %0d want 0", cmd_cnt_r); else passed++;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_good_frame();
    do_reset();
    send_frame(32'h0100_000A, 32'h0000_1234, 32'h0000_0064);
    idle(1);
    total++; if (cmd_vld_r !== 1'b0) $display("FAIL good_lat1_vld got %b want 0", cmd_vld_r); else passed++;
    total++; if (in_rdy !== 1'b0)    $display("FAIL good_hold_rdy got %b want 0", in_rdy);    else passed++;
    idle(1);
    total++; if (cmd_vld_r !== 1'b1) $display("FAIL good_lat2_vld got %b want 1", cmd_vld_r); else passed++;
    total++; if (cmd_r !== 96'h0100000A_00001234_00000064)
      $display("FAIL good_cmd got %h want 0100000a0000123400000064", cmd_r); else passed++;
    idle(1);
    total++; if (cmd_vld_r !== 1'b0) $display("FAIL good_vld_drop got %b want 0", cmd_vld_r); else passed++;
    total++; if (cmd_cnt_r !== 16'd1) $display("FAIL good_cmd_cnt got %0d want 1", cmd_cnt_r); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    cmd_full_r = 1'b1;
    send_frame(32'h0100_000A, 32'h0000_1234, 32'h0000_0064);
    fork
      begin
        send_frame(32'h0200_0005, 32'h0000_BEEF, 32'h0000_0077);
        idle(1);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          total++; if (in_rdy !== 1'b0) $display("FAIL bp_rdy got %b want 0", in_rdy); else passed++;
          total++; if (cmd_r !== 96'h0100000A_00001234_00000064)
            $display("FAIL bp_cmd_stable got %h want 0100000a0000123400000064", cmd_r); else passed++;
          total++; if (cmd_vld_r !== 1'b0) $display("FAIL bp_no_strobe got %b want 0", cmd_vld_r); else passed++;
        end
        cmd_full_r = 1'b0;
        @(negedge clk);
        total++; if (cmd_vld_r !== 1'b1) $display("FAIL bp_release_strobe got %b want 1", cmd_vld_r); else passed++;
      end
    join
    idle(6);
    total++; if (cmd_cnt_r !== 16'd2) $display("FAIL bp_cmd_cnt got %0d want 2", cmd_cnt_r); else passed++;
    total++; if (exp_q.size() != 0) $display("FAIL bp_pending got %0d want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_early_eop();
    do_reset();
    send_beat(1'b1, 1'b0, 32'hAAAA_0001);
    send_beat(1'b0, 1'b1, 32'hAAAA_0002);
    idle(3);
    total++; if (cmd_cnt_r !== 16'd0) $display("FAIL early_no_cmd got %0d want 0", cmd_cnt_r); else passed++;
    send_frame(32'h0300_0001, 32'h0000_0042, 32'h0000_1000);
    idle(6);
    total++; if (err_cnt_r !== 8'd1)  $display("FAIL early_err got %0d want 1", err_cnt_r); else passed++;
    total++; if (cmd_cnt_r !== 16'd1) $display("FAIL early_cmd_cnt got %0d want 1", cmd_cnt_r); else passed++;
  endtask

  task automatic test_mid_sop();
    do_reset();
    send_beat(1'b1, 1'b0, 32'h1111_1111);
    send_beat(1'b0, 1'b0, 32'h2222_2222);
    send_beat(1'b1, 1'b0, 32'h0400_0009);
    send_beat(1'b0, 1'b0, 32'h0000_5555);
    send_beat(1'b0, 1'b1, 32'h0000_6666);
    idle(6);
    total++; if (err_cnt_r !== 8'd1)  $display("FAIL midsop_err got %0d want 1", err_cnt_r); else passed++;
    total++; if (cmd_cnt_r !== 16'd1) $display("FAIL midsop_cmd_cnt got %0d want 1", cmd_cnt_r); else passed++;
  endtask

  task automatic test_overlong();
    do_reset();
    send_beat(1'b1, 1'b0, 32'h5000_0001);
    send_beat(1'b0, 1'b0, 32'h5000_0002);
    send_beat(1'b0, 1'b0, 32'h5000_0003);
    send_beat(1'b0, 1'b1, 32'h5000_0004);
    idle(3);
    total++; if (err_cnt_r !== 8'd1)  $display("FAIL long_err got %0d want 1", err_cnt_r); else passed++;
    total++; if (cmd_cnt_r !== 16'd0) $display("FAIL long_no_cmd got %0d want 0", cmd_cnt_r); else passed++;
    send_frame(32'h0600_0002, 32'h0000_0007, 32'h0000_0008);
    idle(6);
    total++; if (cmd_cnt_r !== 16'd1) $display("FAIL long_recover got %0d want 1", cmd_cnt_r); else passed++;
    total++; if (err_cnt_r !== 8'd1)  $display("FAIL long_err_after got %0d want 1", err_cnt_r); else passed++;
  endtask

  task automatic test_reset_hold();
    do_reset();
    send_beat(1'b0, 1'b1, 32'hDEAD_0000);
    send_frame(32'h0700_0001, 32'h0000_0002, 32'h0000_0003);
    idle(6);
    cmd_full_r = 1'b1;
    send_frame(32'h0800_0001, 32'h0000_0004, 32'h0000_0005);
    idle(2);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    total++; if (cmd_vld_r !== 1'b0)  $display("FAIL rsthold_vld got %b want 0", cmd_vld_r); else passed++;
    total++; if (err_cnt_r !== 8'd0)  $display("FAIL rsthold_err got %0d want 0", err_cnt_r); else passed++;
    total++; if (cmd_cnt_r !== 16'd0) $display("FAIL rsthold_cnt got %0d want 0", cmd_cnt_r); else passed++;
    total++; if (in_rdy !== 1'b1)     $display("FAIL rsthold_rdy got %b want 1", in_rdy);     else passed++;
    idle(1);
    rst = 1'b1;
    cmd_full_r = 1'b0;
    idle(8);
    total++; if (cmd_cnt_r !== 16'd0) $display("FAIL rsthold_no_strobe got %0d want 0", cmd_cnt_r); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (300) send_beat(1'b1, 1'b1, $urandom);
    idle(2);
    total++; if (err_cnt_r !== 8'(sat_err(model_err)))
      $display("FAIL sat_err got %0d want %0d", err_cnt_r, sat_err(model_err)); else passed++;
    total++; if (err_cnt_r !== 8'd255) $display("FAIL sat_err_max got %0d want 255", err_cnt_r); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    rand_full = 1'b1;
    for (int f = 0; f < 150; f++) begin
      int kind;
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1, 2: send_frame($urandom, $urandom, $urandom);
        3: begin
          send_beat(1'b1, 1'b0, $urandom);
          if ($urandom_range(0, 1) == 1) send_beat(1'b0, 1'b0, $urandom);
          send_beat(1'b0, 1'b1, $urandom);
        end
        4: begin
          send_beat(1'b1, 1'b0, $urandom);
          repeat ($urandom_range(2, 3)) send_beat(1'b0, 1'b0, $urandom);
          send_beat(1'b0, 1'b1, $urandom);
        end
        default: send_beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      endcase
      idle($urandom_range(0, 2));
    end
    rand_full = 1'b0;
    cmd_full_r = 1'b0;
    idle(10);
    total++; if (err_cnt_r !== 8'(sat_err(model_err)))
      $display("FAIL rand_err got %0d want %0d", err_cnt_r, sat_err(model_err)); else passed++;
    total++; if (cmd_cnt_r !== 16'(model_cmd))
      $display("FAIL rand_cmd_cnt got %0d want %0d", cmd_cnt_r, model_cmd); else passed++;
    total++; if (exp_q.size() != 0) $display("FAIL rand_pending got %0d want 0", exp_q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_backpressure();
    test_early_eop();
    test_mid_sop();
    test_overlong();
    test_reset_hold();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
